// File: rtl/aes32_round_unit.sv
// AES32 scalar-round unit: computes one byte lane of an AES round
// (esi/esmi/dsi/dsmi) over several cycles. The S-box is derived on the fly
// by inverting in GF(2^8) with square-and-multiply (x^254).
module aes32_round_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       bs,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_INV  = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Exponent 254 scanned MSB first gives x^-1 (and 0 -> 0).
  localparam logic [7:0] INV_EXP = 8'hFE;

  logic [2:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       bs_q, bs_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       r_q, r_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [7:0]       sq;
  logic [7:0]       s;
  logic [31:0]      w;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Bit i = x[i+2] ^ x[i+5] ^ x[i+7] ^ 0x05[i], expressed as right rotations.
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
  endfunction

  // Bit i = r[i] ^ r[i+4] ^ r[i+5] ^ r[i+6] ^ r[i+7] ^ 0x63[i].
  function automatic logic [7:0] fwd_affine(input logic [7:0] r);
    return r ^ {r[3:0], r[7:4]} ^ {r[4:0], r[7:5]} ^ {r[5:0], r[7:6]}
             ^ {r[6:0], r[7]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] v, input logic [1:0] n);
    logic [31:0] o;
    case (n)
      2'd0:    o = v;
      2'd1:    o = {v[23:0], v[31:24]};
      2'd2:    o = {v[15:0], v[31:16]};
      default: o = {v[7:0],  v[31:8]};
    endcase
    return o;
  endfunction

  // Next-state logic: capture, affine pre-step, inversion steps, result build.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    bs_d     = bs_q;
    rs1_d    = rs1_q;
    x_d      = x_q;
    r_d      = r_q;
    result_d = result_q;
    sq       = gmul(r_q, r_q);
    s        = op_q[1] ? r_q : fwd_affine(r_q);
    case (op_q)
      2'b01:   w = {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
      2'b11:   w = {gmul(s, 8'h0B), gmul(s, 8'h0D), gmul(s, 8'h09), gmul(s, 8'h0E)};
      default: w = {24'h0, s};
    endcase
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d    = op;
          bs_d    = bs;
          rs1_d   = rs1;
          x_d     = rs2[8*bs +: 8];
          state_d = S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (op_q[1]) x_d = inv_affine(x_q);
        r_d     = 8'h01;
        cnt_d   = 3'd0;
        state_d = S_INV;
      end
      S_INV: begin
        r_d   = INV_EXP[3'd7 - cnt_q] ? gmul(sq, x_q) : sq;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_POST;
      end
      S_POST: begin
        result_d = rs1_q ^ rotl_bytes(w, bs_q);
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and the architecturally visible result are cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Operand and working registers are only meaningful while a request runs.
  always_ff @(posedge clock) begin
    op_q  <= op_d;
    bs_q  <= bs_d;
    rs1_q <= rs1_d;
    x_q   <= x_d;
    r_q   <= r_d;
  end

  assign busy   = (state_q == S_PRE) || (state_q == S_INV) || (state_q == S_POST);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_aes32_round_unit.sv
// Directed bench for aes32_round_unit: known S-box / inverse S-box vectors,
// MixColumn-style lanes, busy-time start rejection, back-to-back requests
// and mid-operation reset.
module tb_aes32_round_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  bs;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total;
  int passed;
  int fails;
  int n;
  int pulses;
  logic [31:0] seen;

  aes32_round_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .bs     (bs),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then check busy, latency, busy-at-done and result.
  task automatic run(input string tag, input logic [1:0] o, input logic [1:0] b,
                     input logic [31:0] a, input logic [31:0] src, input logic [31:0] exp);
    op    = o;
    bs    = b;
    rs1   = a;
    rs2   = src;
    start = 1'b1;
    tick();
    start = 1'b0;
    rs1   = 32'hDEADBEEF;
    rs2   = 32'hA5A5A5A5;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 32'd10);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, result, exp);
    tick();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    fails  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'd0;
    bs     = 2'd0;
    rs1    = 32'h0;
    rs2    = 32'h0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    reset = 1'b0;
    tick();

    // Forward S-box lanes
    run("esi_53",       2'b00, 2'd0, 32'h00000000, 32'h00000053, 32'h000000ED);
    run("esi_00",       2'b00, 2'd0, 32'h00000000, 32'h00000000, 32'h00000063);
    run("esi_bs2",      2'b00, 2'd2, 32'h11111111, 32'h00530000, 32'h11FC1111);
    run("esi_bs3",      2'b00, 2'd3, 32'h00000000, 32'h01000000, 32'h7C000000);
    run("esmi_01",      2'b01, 2'd0, 32'hFFFFFFFF, 32'h00000001, 32'h7B838307);
    run("esmi_bs1",     2'b01, 2'd1, 32'h00000000, 32'h00005300, 32'hEDEDC12C);
    // Inverse S-box lanes
    run("dsi_52",       2'b10, 2'd0, 32'h00000000, 32'h00000052, 32'h00000048);
    run("dsi_63",       2'b10, 2'd0, 32'h00000000, 32'h00000063, 32'h00000000);
    run("dsmi_7c",      2'b11, 2'd0, 32'h00000000, 32'h0000007C, 32'h0B0D090E);

    // Start while busy, with operands changed mid-flight
    op    = 2'b00;
    bs    = 2'd0;
    rs1   = 32'h0;
    rs2   = 32'h00000053;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    start = 1'b1;
    op    = 2'b11;
    rs1   = 32'hFFFFFFFF;
    rs2   = 32'h00000000;
    tick();
    start  = 1'b0;
    pulses = 0;
    seen   = 32'h0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) begin
        pulses++;
        seen = result;
      end
    end
    check("busy_start_pulses", pulses, 32'd1);
    check("busy_start_result", seen, 32'h000000ED);

    // Start held high: back-to-back requests
    op    = 2'b00;
    bs    = 2'd0;
    rs1   = 32'h0;
    rs2   = 32'h00000001;
    start = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("held_first_latency", n, 32'd11);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 20);
    start = 1'b0;
    check("held_period", n, 32'd11);
    check("held_result", result, 32'h0000007C);
    tick();
    tick();

    // Reset during the fourth inversion cycle
    op    = 2'b00;
    bs    = 2'd0;
    rs1   = 32'h0;
    rs2   = 32'h00000053;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'h0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 32'd0);
    run("after_reset", 2'b11, 2'd0, 32'h00000000, 32'h0000007C, 32'h0B0D090E);

    // Reset and start in the same cycle: reset wins
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rst_start_busy2", {31'd0, busy}, 32'd0);
    check("rst_start_result", result, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
